// File: rtl/daq_run_scheduler_pkg.sv
// Shared definitions for the DAQ run scheduler: state encoding, timing defaults,
// reset values and the span-to-load conversion used by the interval counters.
package daq_run_scheduler_pkg;

    typedef enum logic [3:0] {
        ST_IDLE         = 4'd0,
        ST_ARM          = 4'd1,
        ST_TRIG_HIGH    = 4'd2,
        ST_WAIT_ONCE    = 4'd3,
        ST_GAP          = 4'd4,
        ST_STOP         = 4'd5,
        ST_WAIT_ALLDONE = 4'd6,
        ST_FLUSH        = 4'd7,
        ST_CLOSE        = 4'd8
    } daqState_t;

    localparam int unsigned ARM_CYCLES_DEFAULT   = 32'd64;
    localparam int unsigned GUARD_CYCLES_DEFAULT = 32'd8;
    localparam int unsigned TIMEOUT_W_DEFAULT    = 32'd24;

    localparam daqState_t   RST_STATE     = ST_IDLE;
    localparam logic        RST_LEVEL     = 1'b0;
    localparam logic [15:0] RST_ACQ_COUNT = 16'h0000;

    // A span of N cycles loads N-1 so the counter reaches zero in its Nth cycle; 0 acts as 1.
    function automatic logic [15:0] spanLoad16(input logic [15:0] span);
        if (span == 16'd0) begin
            return 16'd0;
        end else begin
            return span - 16'd1;
        end
    endfunction

    function automatic logic [7:0] spanLoad8(input logic [7:0] span);
        if (span == 8'd0) begin
            return 8'd0;
        end else begin
            return span - 8'd1;
        end
    endfunction

endpackage

// File: rtl/daq_run_scheduler_interval_counter.sv
// Loadable saturating down-counter; done is high while the count sits at zero.
// Used for the arm/guard hold, the trigger width, the trigger period and the watchdog.
module daq_interval_counter #(
    parameter int unsigned W = 32'd16
) (
    input  logic         Clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] loadValue,
    input  logic         enable,
    output logic         done
);

    logic [W-1:0] cntR;
    logic [W-1:0] cntNext;

    // Next count: load wins, otherwise count down and hold at zero.
    always_comb begin
        cntNext = cntR;
        if (load) begin
            cntNext = loadValue;
        end else if (enable && !done) begin
            cntNext = cntR - {{(W-1){1'b0}}, 1'b1};
        end else begin
            cntNext = cntR;
        end
    end

    // Count register with registered zero flag.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            cntR <= {W{1'b0}};
            done <= 1'b1;
        end else begin
            cntR <= cntNext;
            done <= (cntNext == {W{1'b0}});
        end
    end

endmodule

// File: rtl/daq_run_scheduler.sv
// Run-level sequencer for the slave DAQ: arms the slave, issues self-timed AcqStart
// pulses paced by period and OnceEnd, then closes the run via AllDone/FIFO handshake.
module daq_run_scheduler
    import daq_run_scheduler_pkg::*;
#(
    parameter int unsigned ARM_CYCLES   = ARM_CYCLES_DEFAULT,
    parameter int unsigned GUARD_CYCLES = GUARD_CYCLES_DEFAULT,
    parameter int unsigned TIMEOUT_W    = TIMEOUT_W_DEFAULT
) (
    input  logic                 Clk,
    input  logic                 reset,
    input  logic                 RunStart,
    input  logic                 RunStop,
    input  logic [15:0]          TrigPeriod,
    input  logic [7:0]           TrigWidth,
    input  logic [15:0]          AcqNumber,
    input  logic [TIMEOUT_W-1:0] TimeoutLimit,
    input  logic                 OnceEnd,
    input  logic                 AllDone,
    input  logic                 FifoEmpty,
    output logic                 ModuleStart,
    output logic                 AcqStart,
    output logic                 DataTransmitDone,
    output logic [15:0]          AcqCount,
    output logic                 Busy,
    output logic                 RunDone,
    output logic                 TimeoutError
);

    localparam logic [15:0] ARM_LOAD = 16'(ARM_CYCLES - 32'd1);
    // The OnceEnd fall is seen one cycle before GAP is entered, so GAP counts two fewer.
    localparam logic [15:0] GUARD_LOAD = (GUARD_CYCLES > 32'd1) ? 16'(GUARD_CYCLES - 32'd2) : 16'd0;
    localparam logic [TIMEOUT_W-1:0] WD_ONE = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

    daqState_t stateR, stateNext;

    logic runStartD, onceEndD;
    logic runStartRise, onceRise, onceFall;
    logic seenRiseR, seenRiseNext;
    logic stopLatchedR, stopLatchedNext;
    logic wdEnR, wdEnNext;
    logic [15:0] acqNumberR, acqNumberNext;
    logic enterTrig;

    logic moduleStartNext, acqStartNext, dtdNext, busyNext, runDoneNext, timeoutErrorNext;
    logic [15:0] acqCountNext;

    logic holdLoad, widthLoad, periodLoad, wdLoad;
    logic [15:0] holdValue, periodValue;
    logic [7:0]  widthValue;
    logic [TIMEOUT_W-1:0] wdValue;
    logic holdDone, widthDone, periodDone, wdDone;

    assign runStartRise = RunStart & ~runStartD;
    assign onceRise     = OnceEnd & ~onceEndD;
    assign onceFall     = ~OnceEnd & onceEndD;

    assign widthValue  = spanLoad8(TrigWidth);
    assign periodValue = spanLoad16(TrigPeriod);
    assign wdValue     = TimeoutLimit - WD_ONE;

    daq_interval_counter #(.W(32'd16)) uHold (
        .Clk(Clk), .reset(reset), .load(holdLoad), .loadValue(holdValue),
        .enable(1'b1), .done(holdDone)
    );

    daq_interval_counter #(.W(32'd8)) uWidth (
        .Clk(Clk), .reset(reset), .load(widthLoad), .loadValue(widthValue),
        .enable(1'b1), .done(widthDone)
    );

    daq_interval_counter #(.W(32'd16)) uPeriod (
        .Clk(Clk), .reset(reset), .load(periodLoad), .loadValue(periodValue),
        .enable(1'b1), .done(periodDone)
    );

    daq_interval_counter #(.W(TIMEOUT_W)) uWatchdog (
        .Clk(Clk), .reset(reset), .load(wdLoad), .loadValue(wdValue),
        .enable(1'b1), .done(wdDone)
    );

    // Next-state, counter control and next output values.
    always_comb begin
        stateNext        = stateR;
        enterTrig        = 1'b0;
        seenRiseNext     = seenRiseR;
        stopLatchedNext  = stopLatchedR;
        wdEnNext         = wdEnR;
        acqNumberNext    = acqNumberR;
        acqCountNext     = AcqCount;
        timeoutErrorNext = TimeoutError;
        dtdNext          = 1'b0;
        runDoneNext      = 1'b0;
        holdLoad         = 1'b0;
        holdValue        = ARM_LOAD;
        widthLoad        = 1'b0;
        periodLoad       = 1'b0;
        wdLoad           = 1'b0;

        case (stateR)
            ST_IDLE: begin
                if (runStartRise) begin
                    stateNext        = ST_ARM;
                    acqCountNext     = RST_ACQ_COUNT;
                    timeoutErrorNext = 1'b0;
                    stopLatchedNext  = 1'b0;
                    holdLoad         = 1'b1;
                    holdValue        = ARM_LOAD;
                end else begin
                    stateNext = ST_IDLE;
                end
            end
            ST_ARM: begin
                if (RunStop) begin
                    stateNext = ST_STOP;
                end else if (holdDone) begin
                    stateNext = ST_TRIG_HIGH;
                    enterTrig = 1'b1;
                end else begin
                    stateNext = ST_ARM;
                end
            end
            ST_TRIG_HIGH: begin
                if (RunStop) begin
                    stopLatchedNext = 1'b1;
                end else begin
                    stopLatchedNext = stopLatchedR;
                end
                // A fast slave may raise OnceEnd while the trigger is still high.
                if (onceRise) begin
                    seenRiseNext = 1'b1;
                end else begin
                    seenRiseNext = seenRiseR;
                end
                if (widthDone) begin
                    stateNext = ST_WAIT_ONCE;
                end else begin
                    stateNext = ST_TRIG_HIGH;
                end
            end
            ST_WAIT_ONCE: begin
                if (RunStop) begin
                    stopLatchedNext = 1'b1;
                end else begin
                    stopLatchedNext = stopLatchedR;
                end
                if (onceFall && seenRiseR) begin
                    stateNext     = ST_GAP;
                    holdLoad      = 1'b1;
                    holdValue     = GUARD_LOAD;
                    acqNumberNext = AcqNumber;
                end else begin
                    if (onceRise) begin
                        seenRiseNext = 1'b1;
                    end else begin
                        seenRiseNext = seenRiseR;
                    end
                    if (wdEnR && wdDone) begin
                        timeoutErrorNext = 1'b1;
                        stateNext        = ST_STOP;
                    end else begin
                        stateNext = ST_WAIT_ONCE;
                    end
                end
            end
            ST_GAP: begin
                if (RunStop || stopLatchedR) begin
                    stateNext = ST_STOP;
                end else if (holdDone && periodDone) begin
                    if ((acqNumberR != 16'd0) && (AcqCount == acqNumberR)) begin
                        stateNext = ST_STOP;
                    end else begin
                        stateNext = ST_TRIG_HIGH;
                        enterTrig = 1'b1;
                    end
                end else begin
                    stateNext = ST_GAP;
                end
            end
            ST_STOP: begin
                stateNext = ST_WAIT_ALLDONE;
            end
            ST_WAIT_ALLDONE: begin
                if (AllDone) begin
                    stateNext = ST_FLUSH;
                end else begin
                    stateNext = ST_WAIT_ALLDONE;
                end
            end
            ST_FLUSH: begin
                if (FifoEmpty) begin
                    dtdNext   = 1'b1;
                    stateNext = ST_CLOSE;
                end else begin
                    stateNext = ST_FLUSH;
                end
            end
            ST_CLOSE: begin
                if (!AllDone) begin
                    runDoneNext = 1'b1;
                    stateNext   = ST_IDLE;
                end else begin
                    stateNext = ST_CLOSE;
                end
            end
            default: begin
                stateNext = ST_IDLE;
            end
        endcase

        if (enterTrig) begin
            widthLoad    = 1'b1;
            periodLoad   = 1'b1;
            wdLoad       = 1'b1;
            wdEnNext     = (TimeoutLimit != {TIMEOUT_W{1'b0}});
            seenRiseNext = 1'b0;
            acqCountNext = AcqCount + 16'd1;
        end else begin
            widthLoad = 1'b0;
        end

        moduleStartNext = (stateNext == ST_ARM) || (stateNext == ST_TRIG_HIGH) ||
                          (stateNext == ST_WAIT_ONCE) || (stateNext == ST_GAP);
        acqStartNext    = (stateNext == ST_TRIG_HIGH);
        busyNext        = (stateNext != ST_IDLE);
    end

    // State, run context and registered outputs.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            stateR           <= RST_STATE;
            runStartD        <= RST_LEVEL;
            onceEndD         <= RST_LEVEL;
            seenRiseR        <= 1'b0;
            stopLatchedR     <= 1'b0;
            wdEnR            <= 1'b0;
            acqNumberR       <= 16'd0;
            ModuleStart      <= RST_LEVEL;
            AcqStart         <= RST_LEVEL;
            DataTransmitDone <= RST_LEVEL;
            AcqCount         <= RST_ACQ_COUNT;
            Busy             <= RST_LEVEL;
            RunDone          <= RST_LEVEL;
            TimeoutError     <= RST_LEVEL;
        end else begin
            stateR           <= stateNext;
            runStartD        <= RunStart;
            onceEndD         <= OnceEnd;
            seenRiseR        <= seenRiseNext;
            stopLatchedR     <= stopLatchedNext;
            wdEnR            <= wdEnNext;
            acqNumberR       <= acqNumberNext;
            ModuleStart      <= moduleStartNext;
            AcqStart         <= acqStartNext;
            DataTransmitDone <= dtdNext;
            AcqCount         <= acqCountNext;
            Busy             <= busyNext;
            RunDone          <= runDoneNext;
            TimeoutError     <= timeoutErrorNext;
        end
    end

endmodule

// File: tb/tb_daq_run_scheduler.sv
// Self-checking bench for daq_run_scheduler: a slave/USB model drives the DUT and
// trigger/close-out timing is predicted from the run-level timing rules.
module tb_daq_run_scheduler;

    localparam int ARM   = 64;
    localparam int GUARD = 8;

    logic        Clk = 1'b0;
    logic        reset = 1'b1;
    logic        RunStart = 1'b0;
    logic        RunStop = 1'b0;
    logic [15:0] TrigPeriod = 16'd0;
    logic [7:0]  TrigWidth = 8'd0;
    logic [15:0] AcqNumber = 16'd0;
    logic [23:0] TimeoutLimit = 24'd0;
    logic        OnceEnd = 1'b0;
    logic        AllDone = 1'b0;
    logic        FifoEmpty = 1'b1;
    logic        ModuleStart, AcqStart, DataTransmitDone, Busy, RunDone, TimeoutError;
    logic [15:0] AcqCount;

    daq_run_scheduler dut (
        .Clk(Clk), .reset(reset), .RunStart(RunStart), .RunStop(RunStop),
        .TrigPeriod(TrigPeriod), .TrigWidth(TrigWidth), .AcqNumber(AcqNumber),
        .TimeoutLimit(TimeoutLimit), .OnceEnd(OnceEnd), .AllDone(AllDone),
        .FifoEmpty(FifoEmpty), .ModuleStart(ModuleStart), .AcqStart(AcqStart),
        .DataTransmitDone(DataTransmitDone), .AcqCount(AcqCount), .Busy(Busy),
        .RunDone(RunDone), .TimeoutError(TimeoutError)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int nAssert = 0;
    int nFail = 0;

    int trigTimes[$];
    int widths[$];
    int dArr[8];
    int hArr[8];
    int curWidth, sRise, sFall;
    bit sActive, slaveOn;
    bit prevAcq, prevMs, prevDtd, prevRd, prevTmo;
    int msRiseCyc, msFallCyc, dtdCyc, dtdHigh, rdCyc, rdHigh, tmoCyc;
    int adDelay, adDrop, adRiseAt, adFallAt, adVisible, fifoHold, fifoReleaseAt;
    bit busyAtRd;

    task automatic check(input string tag, input int obs, input int exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: advance to the falling edge, observe DUT outputs, drive the slave/USB model.
    task automatic step();
        @(negedge Clk);
        if (AcqStart && !prevAcq) begin
            int i;
            i = trigTimes.size();
            if (i > 7) i = 7;
            trigTimes.push_back(cyc);
            sRise = cyc + dArr[i];
            sFall = sRise + hArr[i];
            sActive = slaveOn;
        end
        if (AcqStart) curWidth++;
        else if (prevAcq) begin
            widths.push_back(curWidth);
            curWidth = 0;
        end
        if (sActive && cyc == sRise) OnceEnd = 1'b1;
        if (sActive && cyc == sFall) begin
            OnceEnd = 1'b0;
            sActive = 1'b0;
        end
        if (ModuleStart && !prevMs) msRiseCyc = cyc;
        if (!ModuleStart && prevMs) begin
            msFallCyc = cyc;
            adRiseAt = cyc + adDelay;
        end
        if (cyc == adRiseAt) begin
            AllDone = 1'b1;
            adVisible = cyc;
            if (fifoHold > 0) begin
                FifoEmpty = 1'b0;
                fifoReleaseAt = cyc + fifoHold;
            end
        end
        if (!FifoEmpty && cyc == fifoReleaseAt) FifoEmpty = 1'b1;
        if (DataTransmitDone) begin
            dtdHigh++;
            if (!prevDtd) begin
                dtdCyc = cyc;
                adFallAt = cyc + adDrop;
            end
        end
        if (cyc == adFallAt) AllDone = 1'b0;
        if (RunDone) begin
            rdHigh++;
            if (!prevRd) begin
                rdCyc = cyc;
                busyAtRd = Busy;
            end
        end
        if (TimeoutError && !prevTmo) tmoCyc = cyc;
        prevAcq = AcqStart;
        prevMs  = ModuleStart;
        prevDtd = DataTransmitDone;
        prevRd  = RunDone;
        prevTmo = TimeoutError;
    endtask

    // stopMode: 0 none, 1 RunStop in GAP after trigger stopK, 2 RunStop in WAIT_ONCE of trigger stopK.
    task automatic doRun(input string tag, input int n, input int p, input int w, input int limit,
                         input int stopMode, input int stopK, input int hold, input bit sOn);
        int peff, weff, nStart, eCyc, stopCyc, expCount, fLast, idx, expDtd;
        int expT[$];
        AcqNumber = 16'(n);
        TrigPeriod = 16'(p);
        TrigWidth = 8'(w);
        TimeoutLimit = 24'(limit);
        slaveOn = sOn;
        fifoHold = hold;
        adDelay = $urandom_range(1, 6);
        adDrop = $urandom_range(1, 6);
        trigTimes.delete();
        widths.delete();
        curWidth = 0; sActive = 1'b0; OnceEnd = 1'b0; AllDone = 1'b0; FifoEmpty = 1'b1;
        msRiseCyc = -1; msFallCyc = -1; dtdCyc = -1; rdCyc = -1; tmoCyc = -1;
        dtdHigh = 0; rdHigh = 0; adRiseAt = -1; adFallAt = -1; adVisible = -1; fifoReleaseAt = -1;
        busyAtRd = 1'b1; stopCyc = -1;
        RunStart = 1'b0;
        step();
        step();
        RunStart = 1'b1;
        nStart = cyc;

        peff = (p == 0) ? 1 : p;
        weff = (w == 0) ? 1 : w;
        expT.push_back(nStart + 1 + ARM);
        if (!sOn) begin
            expCount = 1;
            eCyc = expT[0] + limit;
        end else begin
            expCount = (stopMode == 0) ? n : stopK;
            for (int i = 1; i <= expCount; i++) begin
                idx = (i - 1 > 7) ? 7 : i - 1;
                expT.push_back(expT[i-1] + ((peff > dArr[idx] + hArr[idx] + GUARD) ?
                                            peff : dArr[idx] + hArr[idx] + GUARD));
            end
            idx = (expCount - 1 > 7) ? 7 : expCount - 1;
            fLast = expT[expCount-1] + dArr[idx] + hArr[idx];
            if (stopMode == 1) begin
                stopCyc = fLast + 2;
                eCyc = stopCyc + 1;
            end else if (stopMode == 2) begin
                stopCyc = expT[expCount-1] + weff + 1;
                eCyc = fLast + 2;
            end else begin
                eCyc = expT[expCount];
            end
        end

        while (rdHigh == 0 && cyc < nStart + 30000) begin
            step();
            if (cyc == nStart + 3) RunStart = 1'b0;
            RunStop = (stopMode != 0 && cyc == stopCyc);
        end
        RunStop = 1'b0;
        RunStart = 1'b0;
        repeat (5) step();

        check({tag, " ModuleStart rise"}, msRiseCyc, nStart + 1);
        check({tag, " trigger count"}, trigTimes.size(), expCount);
        for (int i = 0; i < expCount && i < trigTimes.size(); i++)
            check({tag, " trigger time"}, trigTimes[i], expT[i]);
        for (int i = 0; i < widths.size(); i++)
            check({tag, " trigger width"}, widths[i], weff);
        check({tag, " AcqCount"}, int'(AcqCount), expCount);
        check({tag, " ModuleStart fall"}, msFallCyc, eCyc);
        if (!sOn) check({tag, " timeout time"}, tmoCyc, eCyc);
        check({tag, " TimeoutError"}, int'(TimeoutError), sOn ? 0 : 1);
        expDtd = ((hold > 1) ? adVisible + hold : adVisible + 1) + 1;
        check({tag, " DataTransmitDone time"}, dtdCyc, expDtd);
        check({tag, " DataTransmitDone width"}, dtdHigh, 1);
        check({tag, " RunDone time"}, rdCyc, dtdCyc + adDrop + 1);
        check({tag, " RunDone width"}, rdHigh, 1);
        check({tag, " Busy at RunDone"}, int'(busyAtRd), 0);
        check({tag, " Busy idle"}, int'(Busy), 0);
    endtask

    initial begin
        int n, p, w, weff;
        slaveOn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            dArr[i] = 20;
            hArr[i] = 10;
        end
        step();
        step();
        check("reset ModuleStart", int'(ModuleStart), 0);
        check("reset AcqStart", int'(AcqStart), 0);
        check("reset DataTransmitDone", int'(DataTransmitDone), 0);
        check("reset AcqCount", int'(AcqCount), 0);
        check("reset Busy", int'(Busy), 0);
        check("reset RunDone", int'(RunDone), 0);
        check("reset TimeoutError", int'(TimeoutError), 0);
        reset = 1'b0;
        step();
        check("idle Busy", int'(Busy), 0);

        doRun("basic3", 3, 100, 4, 0, 0, 0, 0, 1'b1);

        dArr[0] = 140; hArr[0] = 10;
        doRun("slow_once", 2, 100, 4, 0, 0, 0, 0, 1'b1);

        doRun("timeout", 3, 100, 4, 1000, 0, 0, 0, 1'b0);

        for (int i = 0; i < 8; i++) begin dArr[i] = 5; hArr[i] = 5; end
        doRun("stop_gap", 0, 50, 2, 0, 1, 5, 0, 1'b1);

        for (int i = 0; i < 8; i++) begin dArr[i] = 10; hArr[i] = 5; end
        doRun("stop_latched", 0, 200, 3, 0, 2, 2, 0, 1'b1);

        doRun("fifo_hold", 1, 30, 2, 0, 0, 0, 500, 1'b1);

        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 4);
            p = $urandom_range(0, 160);
            w = $urandom_range(0, 10);
            weff = (w == 0) ? 1 : w;
            for (int i = 0; i < 8; i++) begin
                dArr[i] = $urandom_range(weff + 1, 70);
                hArr[i] = $urandom_range(1, 40);
            end
            doRun("random", n, p, w, (r % 2 == 0) ? 50000 : 0, 0, 0, $urandom_range(0, 20), 1'b1);
        end

        // Asynchronous reset while the trigger is high.
        for (int i = 0; i < 8; i++) begin dArr[i] = 30; hArr[i] = 5; end
        AcqNumber = 16'd2; TrigPeriod = 16'd100; TrigWidth = 8'd20; TimeoutLimit = 24'd0;
        RunStart = 1'b0;
        step();
        RunStart = 1'b1;
        for (int i = 0; i < 200 && !AcqStart; i++) step();
        repeat (3) step();
        check("pre-reset AcqStart", int'(AcqStart), 1);
        #2 reset = 1'b1;
        #1;
        check("async reset AcqStart", int'(AcqStart), 0);
        check("async reset ModuleStart", int'(ModuleStart), 0);
        check("async reset Busy", int'(Busy), 0);
        check("async reset AcqCount", int'(AcqCount), 0);
        step();
        step();
        reset = 1'b0;
        RunStart = 1'b0;
        step();
        doRun("post_reset", 1, 30, 3, 0, 0, 0, 0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
